// File: rtl/gate_sweep_checker_if.sv
// Signal bundle between the sweep checker and whoever starts it and observes
// its results. The dut_q/vec_out pair is the path to the gate under test.
interface gate_sweep_checker_if #(
    parameter int N_INPUTS = 2
);
    logic                start;
    logic                dut_q;
    logic [N_INPUTS-1:0] vec_out;
    logic                busy;
    logic                done;
    logic                pass;
    logic [N_INPUTS:0]   err_count;
    logic                first_fail_valid;
    logic [N_INPUTS-1:0] first_fail_vec;

    // Checker side: drives vectors and results, observes start and the gate output.
    modport master (
        input  start,
        input  dut_q,
        output vec_out,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_fail_valid,
        output first_fail_vec
    );

    // Controller/gate side: pulses start and returns the gate output.
    modport slave (
        output start,
        output dut_q,
        input  vec_out,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_fail_valid,
        input  first_fail_vec
    );
endinterface

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table checker for small combinational gates. Walks every
// input vector in ascending order, holds each for SETTLE_CYCLES clocks, then
// samples the gate output once and compares it with EXPECTED[vector].
module gate_sweep_checker #(
    parameter int                         N_INPUTS      = 2,
    parameter int                         SETTLE_CYCLES = 2,
    parameter logic [(2**N_INPUTS)-1:0]   EXPECTED      = 4'b0111
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gate_sweep_checker_if.master   sweep
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
    localparam logic [N_INPUTS-1:0] IDX_LAST    = N_INPUTS'((2**N_INPUTS) - 1);
    localparam logic [N_INPUTS-1:0] IDX_ONE     = N_INPUTS'(1);
    localparam logic [N_INPUTS:0]   ERR_ONE     = (N_INPUTS + 1)'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [N_INPUTS-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [N_INPUTS:0]   err_count_q, err_count_d;
    logic                ff_valid_q, ff_valid_d;
    logic [N_INPUTS-1:0] ff_vec_q, ff_vec_d;
    logic                mismatch;

    // Case-inequality so an X/Z from the gate is counted as a failure in
    // simulation; synthesis reduces it to an ordinary compare.
    assign mismatch = (sweep.dut_q !== EXPECTED[idx_q]);

    // Sweep sequencing and result accumulation.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        settle_cnt_d = settle_cnt_q;
        err_count_d  = err_count_q;
        ff_valid_d   = ff_valid_q;
        ff_vec_d     = ff_vec_q;
        case (state_q)
            IDLE, DONE: begin
                if (sweep.start) begin
                    idx_d        = '0;
                    settle_cnt_d = '0;
                    err_count_d  = '0;
                    ff_valid_d   = 1'b0;
                    ff_vec_d     = '0;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                // Counter stops at its terminal value; SAMPLE reloads it.
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + CNT_ONE;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_count_d = err_count_q + ERR_ONE;
                    if (!ff_valid_q) begin
                        ff_valid_d = 1'b1;
                        ff_vec_d   = idx_q;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d        = idx_q + IDX_ONE;
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            settle_cnt_q <= '0;
            err_count_q  <= '0;
            ff_valid_q   <= 1'b0;
            ff_vec_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            settle_cnt_q <= settle_cnt_d;
            err_count_q  <= err_count_d;
            ff_valid_q   <= ff_valid_d;
            ff_vec_q     <= ff_vec_d;
        end
    end

    // The vector index is the gate stimulus, so vec_out only moves on the
    // edge that enters SETTLE.
    assign sweep.vec_out          = idx_q;
    assign sweep.busy             = (state_q == SETTLE) || (state_q == SAMPLE);
    assign sweep.done             = (state_q == DONE);
    assign sweep.pass             = (state_q == DONE) && (err_count_q == '0);
    assign sweep.err_count        = err_count_q;
    assign sweep.first_fail_valid = ff_valid_q;
    assign sweep.first_fail_vec   = ff_vec_q;
endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: a default 2-input NAND checker and a 1-input
// buffer checker with a one-clock settle, each fed by a behavioural gate.
module tb_gate_sweep_checker;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   mode_a;
    int   mode_b;

    always #5 clk = ~clk;

    gate_sweep_checker_if #(.N_INPUTS(2)) bus_a ();
    gate_sweep_checker_if #(.N_INPUTS(1)) bus_b ();

    gate_sweep_checker #(
        .N_INPUTS      (2),
        .SETTLE_CYCLES (2),
        .EXPECTED      (4'b0111)
    ) u_nand (
        .clk   (clk),
        .rst_n (rst_n),
        .sweep (bus_a)
    );

    // Buffer truth table: Q=0 for vector 0, Q=1 for vector 1.
    gate_sweep_checker #(
        .N_INPUTS      (1),
        .SETTLE_CYCLES (1),
        .EXPECTED      (2'b10)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .sweep (bus_b)
    );

    // Gate models: 0 = NAND, 1 = AND, 2 = stuck at 1.
    always_comb begin
        case (mode_a)
            0:       bus_a.dut_q = ~&bus_a.vec_out;
            1:       bus_a.dut_q = &bus_a.vec_out;
            default: bus_a.dut_q = 1'b1;
        endcase
    end

    // Gate models: 0 = buffer, 1 = inverter.
    always_comb begin
        bus_b.dut_q = (mode_b == 0) ? bus_b.vec_out[0] : ~bus_b.vec_out[0];
    end

    typedef struct {
        logic [1:0] vec;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        int         mode;
        bit         hold;
        logic [2:0] err;
        logic       ffv;
        logic [1:0] ffvec;
        logic       pass;
        string      name;
    } vec_t;

    obs_t sb_q[$];
    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One sweep on the NAND checker: expected per-cycle observations are
    // queued as start is driven and popped as each clock's outputs appear.
    task automatic sweep_a(input vec_t t);
        obs_t o;
        mode_a = t.mode;
        @(negedge clk);
        bus_a.start = 1'b1;
        for (int j = 0; j <= 12; j++) begin
            o.vec  = (j < 12) ? 2'(j / 3) : 2'd3;
            o.busy = (j < 12);
            o.done = (j == 12);
            sb_q.push_back(o);
        end
        for (int j = 0; j <= 12; j++) begin
            @(negedge clk);
            if (!t.hold) bus_a.start = 1'b0;
            o = sb_q.pop_front();
            check({t.name, ":vec"},  {30'd0, bus_a.vec_out}, {30'd0, o.vec});
            check({t.name, ":busy"}, {31'd0, bus_a.busy},    {31'd0, o.busy});
            check({t.name, ":done"}, {31'd0, bus_a.done},    {31'd0, o.done});
            if (j == 0) begin
                check({t.name, ":err_clr"}, {29'd0, bus_a.err_count}, 32'd0);
                check({t.name, ":ffv_clr"}, {31'd0, bus_a.first_fail_valid}, 32'd0);
            end
        end
        bus_a.start = 1'b0;
        check({t.name, ":err_count"}, {29'd0, bus_a.err_count},        {29'd0, t.err});
        check({t.name, ":ffv"},       {31'd0, bus_a.first_fail_valid}, {31'd0, t.ffv});
        check({t.name, ":ffvec"},     {30'd0, bus_a.first_fail_vec},   {30'd0, t.ffvec});
        check({t.name, ":pass"},      {31'd0, bus_a.pass},             {31'd0, t.pass});
        @(negedge clk);
        check({t.name, ":done_hold"}, {31'd0, bus_a.done}, 32'd1);
        check({t.name, ":busy_hold"}, {31'd0, bus_a.busy}, 32'd0);
    endtask

    // One sweep on the buffer checker: two vectors, two clocks each.
    task automatic sweep_b(input int mode, input logic [1:0] err, input logic ffv,
                           input logic ffvec, input logic pass, input string name);
        mode_b = mode;
        @(negedge clk);
        bus_b.start = 1'b1;
        for (int j = 0; j <= 4; j++) begin
            @(negedge clk);
            bus_b.start = 1'b0;
            check({name, ":vec"},  {31'd0, bus_b.vec_out}, (j < 4) ? 32'(j / 2) : 32'd1);
            check({name, ":done"}, {31'd0, bus_b.done},    (j == 4) ? 32'd1 : 32'd0);
        end
        check({name, ":err_count"}, {30'd0, bus_b.err_count},        {30'd0, err});
        check({name, ":ffv"},       {31'd0, bus_b.first_fail_valid}, {31'd0, ffv});
        check({name, ":ffvec"},     {31'd0, bus_b.first_fail_vec},   {31'd0, ffvec});
        check({name, ":pass"},      {31'd0, bus_b.pass},             {31'd0, pass});
    endtask

    initial begin
        //        mode hold err   ffv   ffvec  pass  name
        tbl[0] = '{0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b1, "nand_ok"};
        tbl[1] = '{1, 1'b0, 3'd4, 1'b1, 2'd0, 1'b0, "and_gate"};
        tbl[2] = '{2, 1'b0, 3'd1, 1'b1, 2'd3, 1'b0, "stuck1"};
        tbl[3] = '{0, 1'b1, 3'd0, 1'b0, 2'd0, 1'b1, "start_held"};
        tbl[4] = '{1, 1'b0, 3'd4, 1'b1, 2'd0, 1'b0, "and_again"};

        rst_n       = 1'b0;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        mode_a      = 0;
        mode_b      = 0;
        repeat (3) @(negedge clk);
        check("rst:vec",   {30'd0, bus_a.vec_out},          32'd0);
        check("rst:busy",  {31'd0, bus_a.busy},             32'd0);
        check("rst:done",  {31'd0, bus_a.done},             32'd0);
        check("rst:pass",  {31'd0, bus_a.pass},             32'd0);
        check("rst:err",   {29'd0, bus_a.err_count},        32'd0);
        check("rst:ffv",   {31'd0, bus_a.first_fail_valid}, 32'd0);
        check("rst:ffvec", {30'd0, bus_a.first_fail_vec},   32'd0);
        check("rst:b_done", {31'd0, bus_b.done},            32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle:busy", {31'd0, bus_a.busy}, 32'd0);

        for (int i = 0; i < 5; i++) sweep_a(tbl[i]);

        // Reset in the middle of a failing sweep, while vector 2'b10 is applied.
        mode_a = 1;
        @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst:vec_before", {30'd0, bus_a.vec_out},   32'd2);
        check("midrst:err_before", {29'd0, bus_a.err_count}, 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst:vec",  {30'd0, bus_a.vec_out},          32'd0);
        check("midrst:busy", {31'd0, bus_a.busy},             32'd0);
        check("midrst:done", {31'd0, bus_a.done},             32'd0);
        check("midrst:err",  {29'd0, bus_a.err_count},        32'd0);
        check("midrst:ffv",  {31'd0, bus_a.first_fail_valid}, 32'd0);
        @(negedge clk);
        check("midrst:idle", {31'd0, bus_a.busy}, 32'd0);
        sweep_a('{0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b1, "after_rst"});

        sweep_b(0, 2'd0, 1'b0, 1'b0, 1'b1, "buf_ok");
        sweep_b(1, 2'd2, 1'b1, 1'b0, 1'b0, "buf_inv");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
